// File: rtl/instruction_issue_unit_pkg.sv
// Shared definitions for the instruction issue unit: opcodes, fetch FSM
// encoding and immediate extraction used by both the fetch and issue sides.
package instruction_issue_unit_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] jal_imm(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] decode_imm(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'b0};
      OP_JAL:                   imm = jal_imm(ins);
      OP_REG:                   imm = '0;
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instruction_issue_unit_decoder.sv
// Purely combinational field split of a 32-bit instruction word.
module instruction_decoder
  import instruction_issue_unit_pkg::*;
(
  input  logic [31:0] ins,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [5:0]  shamt,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];
  assign imm    = decode_imm(ins);
  assign shamt  = ins[25:20];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign rd     = ins[11:7];

endmodule

// File: rtl/instruction_issue_unit.sv
// Fetch front end: fetch FSM with JAL prediction, instruction queue and a
// registered one-cycle issue pulse towards the central schedule unit.
module instruction_issue_unit
  import instruction_issue_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          QUEUE_DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_done,
  input  logic [31:0] fetch_data,
  input  logic        csu_full,
  input  logic        flush_pipline,
  input  logic [31:0] flush_target_pc,
  output logic        ins_just_issued,
  output logic [31:0] issue_PC,
  output logic [31:0] ins_issued,
  output logic [6:0]  issue_opcode,
  output logic [2:0]  issue_funct3,
  output logic [6:0]  issue_funct7,
  output logic [31:0] issue_imm_val,
  output logic [5:0]  issue_shamt_val,
  output logic [4:0]  issue_rs1,
  output logic [4:0]  issue_rs2,
  output logic [4:0]  issue_rd
);

  localparam int AW    = QUEUE_DEPTH_LOG2;
  localparam int DEPTH = 2 ** QUEUE_DEPTH_LOG2;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d, fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   q_pc_q [DEPTH];
  logic [31:0]   q_pc_d [DEPTH];
  logic [31:0]   q_ins_q [DEPTH];
  logic [31:0]   q_ins_d [DEPTH];
  logic          hold_vld_q, hold_vld_d;
  logic [31:0]   hold_data_q, hold_data_d;
  logic          issue_vld_q, issue_vld_d;
  logic [31:0]   issue_pc_q, issue_pc_d, issue_ins_q, issue_ins_d;
  logic          done_eff, push, pop, launch;
  logic [31:0]   done_data;

  always_comb begin
    // A fetch_done seen while stalled is replayed from the holding register.
    done_eff  = rdy_in && (fetch_done || hold_vld_q);
    done_data = hold_vld_q ? hold_data_q : fetch_data;
    push      = done_eff && (state_q == FS_WAIT) && !flush_pipline;
    pop       = rdy_in && (count_q != '0) && !csu_full && !flush_pipline;
    launch    = rdy_in && (state_q == FS_IDLE) && !flush_pipline && (count_q < DEPTH_C);

    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    q_pc_d       = q_pc_q;
    q_ins_d      = q_ins_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    issue_vld_d  = 1'b0;
    issue_pc_d   = issue_pc_q;
    issue_ins_d  = issue_ins_q;

    if (!rdy_in) begin
      if (fetch_done) begin
        hold_vld_d  = 1'b1;
        hold_data_d = fetch_data;
      end
    end else begin
      hold_vld_d = 1'b0;
      if (flush_pipline) begin
        pc_d    = flush_target_pc;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        state_d = ((state_q != FS_IDLE) && !done_eff) ? FS_DISCARD : FS_IDLE;
      end else begin
        case (state_q)
          FS_IDLE: if (launch) begin
            state_d      = FS_WAIT;
            fetch_addr_d = pc_q;
          end
          FS_WAIT: if (done_eff) begin
            state_d = FS_IDLE;
            pc_d    = pc_q + ((done_data[6:0] == OP_JAL) ? jal_imm(done_data) : 32'd4);
          end
          FS_DISCARD: if (done_eff) state_d = FS_IDLE;
          default: state_d = FS_IDLE;
        endcase
        if (push) begin
          q_pc_d[tail_q]  = pc_q;
          q_ins_d[tail_q] = done_data;
          tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
          issue_vld_d = 1'b1;
          issue_pc_d  = q_pc_q[head_q];
          issue_ins_d = q_ins_q[head_q];
          head_d      = head_q + 1'b1;
        end
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      hold_vld_q   <= 1'b0;
      issue_vld_q  <= 1'b0;
      issue_pc_q   <= '0;
      issue_ins_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      hold_vld_q   <= hold_vld_d;
      issue_vld_q  <= issue_vld_d;
      issue_pc_q   <= issue_pc_d;
      issue_ins_q  <= issue_ins_d;
    end
    q_pc_q      <= q_pc_d;
    q_ins_q     <= q_ins_d;
    hold_data_q <= hold_data_d;
  end

  assign fetch_req       = (state_q != FS_IDLE) && !hold_vld_q;
  assign fetch_addr      = fetch_addr_q;
  assign ins_just_issued = issue_vld_q;
  assign issue_PC        = issue_pc_q;
  assign ins_issued      = issue_ins_q;

  // Decoding the registered word keeps every issue_* field aligned with the pulse.
  instruction_decoder u_decoder (
    .ins    (issue_ins_q),
    .opcode (issue_opcode),
    .funct3 (issue_funct3),
    .funct7 (issue_funct7),
    .imm    (issue_imm_val),
    .shamt  (issue_shamt_val),
    .rs1    (issue_rs1),
    .rs2    (issue_rs2),
    .rd     (issue_rd)
  );

endmodule
